// File: rtl/rc4_pkg.sv
// rc4_pkg
// Shared definitions for the RC4 key-scheduling block: the FSM state
// encoding and helpers that derive bus widths from module parameters.
package rc4_pkg;

  // One state per memory-access phase of a KSA iteration.
  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    SV_I,
    CALC_J,
    RD_J,
    WT_J,
    SV_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } ksa_state_t;

  // Width of key_len and of the key byte index: must hold 0..kbm.
  function automatic int unsigned key_len_width(input int unsigned kbm);
    return $clog2(kbm + 1);
  endfunction

  // Width of the read-latency wait counter (counts 0..lat-1, at least 1 bit).
  function automatic int unsigned wait_cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/rc4_key_sel.sv
// rc4_key_sel
// Combinational key byte selector. Byte 0 of the key is its most
// significant byte, so byte b lives at bits [8*(KEY_BYTES_MAX-1-b) +: 8].
// Ports:
//   key      - packed key, byte 0 in the MSBs
//   k        - byte index (values >= KEY_BYTES_MAX select 0)
//   key_byte - selected byte
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES_MAX = 3
) (
  input  logic [8*KEY_BYTES_MAX-1:0]                key,
  input  logic [key_len_width(KEY_BYTES_MAX)-1:0]   k,
  output logic [7:0]                                key_byte
);

  localparam int KLEN_W = key_len_width(KEY_BYTES_MAX);

  always_comb begin
    key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES_MAX; b++) begin
      if (k == KLEN_W'(b)) begin
        key_byte = key[8*(KEY_BYTES_MAX-1-b) +: 8];
      end
    end
  end

endmodule

// File: rtl/rc4_ksa_param.sv
// rc4_ksa_param
// RC4 key-scheduling (S-box scramble) engine driving an external memory
// that already holds the identity permutation. One iteration reads S[i],
// computes j, reads S[j], then swaps the two entries (skipped when i==j).
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   start       - run request, honoured only in IDLE or DONE
//   sec_key     - key, byte 0 = MSB; key_len = active key bytes
//   address     - memory address; data/wren - write data and enable
//   data_read   - read data, valid MEM_LAT cycles after address
//   busy        - high while scrambling; done - level, high in DONE
//   err         - high with done when key_len was 0 or > KEY_BYTES_MAX
module rc4_ksa_param
  import rc4_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int KEY_BYTES_MAX = 3,
  parameter int MEM_LAT       = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [8*KEY_BYTES_MAX-1:0]               sec_key,
  input  logic [key_len_width(KEY_BYTES_MAX)-1:0]  key_len,
  output logic [ADDR_W-1:0]                        address,
  output logic [7:0]                               data,
  output logic                                     wren,
  input  logic [7:0]                               data_read,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err
);

  localparam int KLEN_W = key_len_width(KEY_BYTES_MAX);
  localparam int CNT_W  = wait_cnt_width(MEM_LAT);

  ksa_state_t                state;
  logic [ADDR_W-1:0]         i;
  logic [ADDR_W-1:0]         j;
  logic [KLEN_W-1:0]         k;
  logic [KLEN_W-1:0]         klen_q;
  logic [8*KEY_BYTES_MAX-1:0] key_q;
  logic [7:0]                si;
  logic [7:0]                sj;
  logic [CNT_W-1:0]          wait_cnt;
  logic [7:0]                key_byte;
  logic [ADDR_W-1:0]         j_next;
  logic [KLEN_W-1:0]         k_inc;
  logic                      key_len_bad;

  rc4_key_sel #(
    .KEY_BYTES_MAX (KEY_BYTES_MAX)
  ) u_key_sel (
    .key      (key_q),
    .k        (k),
    .key_byte (key_byte)
  );

  // j update wraps naturally at ADDR_W bits, giving mod N for free.
  assign j_next      = j + ADDR_W'(si) + ADDR_W'(key_byte);
  assign k_inc       = k + KLEN_W'(1);
  assign key_len_bad = (key_len == '0) || (key_len > KLEN_W'(KEY_BYTES_MAX));

  // Write data is a pure decode of the registered state and the two
  // captured S-box values, so it is zero whenever no write is in flight.
  assign data = (state == WR_I) ? sj :
                (state == WR_J) ? si : 8'h00;

  // Main FSM. address/wren/busy/done/err are registered: each is loaded on
  // the transition into the state that needs it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      address  <= '0;
      wren     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      key_q    <= '0;
      klen_q   <= '0;
      wait_cnt <= '0;
    end else begin
      wren <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_q   <= sec_key;
            klen_q  <= key_len;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            address <= '0;
            if (key_len_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RD_I;
              done  <= 1'b0;
              err   <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        RD_I: begin
          wait_cnt <= '0;
          state    <= WT_I;
        end
        WT_I: begin
          if (wait_cnt == CNT_W'(MEM_LAT - 1)) begin
            state <= SV_I;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        SV_I: begin
          si    <= data_read;
          state <= CALC_J;
        end
        CALC_J: begin
          j       <= j_next;
          address <= j_next;
          state   <= RD_J;
        end
        RD_J: begin
          wait_cnt <= '0;
          state    <= WT_J;
        end
        WT_J: begin
          if (wait_cnt == CNT_W'(MEM_LAT - 1)) begin
            state <= SV_J;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        SV_J: begin
          sj <= data_read;
          // A swap of an entry with itself is a no-op, so skip both writes.
          if (i == j) begin
            state <= NEXT;
          end else begin
            state   <= WR_I;
            address <= i;
            wren    <= 1'b1;
          end
        end
        WR_I: begin
          address <= j;
          wren    <= 1'b1;
          state   <= WR_J;
        end
        WR_J: begin
          state <= NEXT;
        end
        NEXT: begin
          i <= i + ADDR_W'(1);
          // Key index wraps at key_len by compare, avoiding a modulo.
          k <= (k_inc == klen_q) ? '0 : k_inc;
          if (i == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= RD_I;
            address <= i + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_param.sv
// tb_rc4_ksa_param
// Two DUT instances: A (ADDR_W=8, KEY_BYTES_MAX=3, MEM_LAT=2) and
// B (ADDR_W=4, KEY_BYTES_MAX=4, MEM_LAT=3), each with a behavioural memory
// of matching read latency. A reference KSA model pushes the expected
// write sequence to a per-instance queue that the write monitors pop.
module tb_rc4_ksa_param;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk;
  logic        reset;

  logic        start_a;
  logic [23:0] sec_key_a;
  logic [1:0]  key_len_a;
  logic [7:0]  addr_a;
  logic [7:0]  data_a;
  logic        wren_a;
  logic [7:0]  rd_a;
  logic        busy_a;
  logic        done_a;
  logic        err_a;

  logic        start_b;
  logic [31:0] sec_key_b;
  logic [2:0]  key_len_b;
  logic [3:0]  addr_b;
  logic [7:0]  data_b;
  logic        wren_b;
  logic [7:0]  rd_b;
  logic        busy_b;
  logic        done_b;
  logic        err_b;

  logic [7:0]  mem_a [256];
  logic [7:0]  pipe_a [LAT_A];
  logic [7:0]  mem_b [16];
  logic [7:0]  pipe_b [LAT_B];
  logic        init_a;
  logic        init_b;

  wr_t qa[$];
  wr_t qb[$];
  int  gold [256];
  int  n_checks;
  int  n_fail;
  int  wr_cnt_a;
  int  wr_cnt_b;

  int  cyc;
  int  exp_cycles;
  int  iter100;
  int  base;

  rc4_ksa_param #(
    .ADDR_W        (8),
    .KEY_BYTES_MAX (3),
    .MEM_LAT       (LAT_A)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start_a),
    .sec_key   (sec_key_a),
    .key_len   (key_len_a),
    .address   (addr_a),
    .data      (data_a),
    .wren      (wren_a),
    .data_read (rd_a),
    .busy      (busy_a),
    .done      (done_a),
    .err       (err_a)
  );

  rc4_ksa_param #(
    .ADDR_W        (4),
    .KEY_BYTES_MAX (4),
    .MEM_LAT       (LAT_B)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .sec_key   (sec_key_b),
    .key_len   (key_len_b),
    .address   (addr_b),
    .data      (data_b),
    .wren      (wren_b),
    .data_read (rd_b),
    .busy      (busy_b),
    .done      (done_b),
    .err       (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: synchronous write, read data delayed LAT_A cycles.
  always @(posedge clk) begin
    if (init_a) begin
      for (int x = 0; x < 256; x++) mem_a[x] <= 8'(x);
    end else if (wren_a) begin
      mem_a[addr_a] <= data_a;
    end
    pipe_a[0] <= mem_a[addr_a];
    for (int p = 1; p < LAT_A; p++) pipe_a[p] <= pipe_a[p-1];
  end
  assign rd_a = pipe_a[LAT_A-1];

  // Memory B: 16 entries, read data delayed LAT_B cycles.
  always @(posedge clk) begin
    if (init_b) begin
      for (int x = 0; x < 16; x++) mem_b[x] <= 8'(x);
    end else if (wren_b) begin
      mem_b[addr_b] <= data_b;
    end
    pipe_b[0] <= mem_b[addr_b];
    for (int p = 1; p < LAT_B; p++) pipe_b[p] <= pipe_b[p-1];
  end
  assign rd_b = pipe_b[LAT_B-1];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitors: every write pulse must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (wren_a) begin
      wr_cnt_a++;
      check_output("A write expected", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_output("A write addr", 32'(addr_a), e.addr);
        check_output("A write data", 32'(data_a), e.data);
      end
    end
    if (wren_b) begin
      wr_cnt_b++;
      check_output("B write expected", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_output("B write addr", 32'(addr_b), e.addr);
        check_output("B write data", 32'(data_b), e.data);
      end
    end
  end

  // Reference KSA on an identity S-box: queues expected writes, fills gold[],
  // and returns the total run length and the cycle at which iteration 100 starts.
  task automatic run_model(input int n, input int lat, input logic [31:0] key, input int kbm,
                           input int len, input bit use_b, output int cycles, output int it100);
    int s [256];
    int jj;
    int kb;
    int t;
    jj = 0;
    cycles = 0;
    it100 = 0;
    for (int x = 0; x < n; x++) s[x] = x;
    for (int ii = 0; ii < n; ii++) begin
      if (ii == 100) it100 = cycles;
      kb = int'((key >> (8 * (kbm - 1 - (ii % len)))) & 32'hff);
      jj = (jj + s[ii] + kb) % n;
      if (ii != jj) begin
        if (use_b) begin
          qb.push_back('{addr: ii, data: s[jj]});
          qb.push_back('{addr: jj, data: s[ii]});
        end else begin
          qa.push_back('{addr: ii, data: s[jj]});
          qa.push_back('{addr: jj, data: s[ii]});
        end
        t = s[ii];
        s[ii] = s[jj];
        s[jj] = t;
        cycles += 8 + 2 * lat;
      end else begin
        cycles += 6 + 2 * lat;
      end
    end
    for (int x = 0; x < n; x++) gold[x] = s[x];
  endtask

  task automatic init_mems();
    init_a = 1'b1;
    init_b = 1'b1;
    @(posedge clk);
    #1;
    init_a = 1'b0;
    init_b = 1'b0;
  endtask

  task automatic apply_start_a(input logic [23:0] key, input logic [1:0] len);
    sec_key_a = key;
    key_len_a = len;
    start_a   = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic apply_start_b(input logic [31:0] key, input logic [2:0] len);
    sec_key_b = key;
    key_len_b = len;
    start_b   = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int from, input int budget, output int c);
    c = from;
    while (!done_a && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_output("A done within budget", 32'(done_a), 32'd1);
  endtask

  task automatic wait_done_b(input int from, input int budget, output int c);
    c = from;
    while (!done_b && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_output("B done within budget", 32'(done_b), 32'd1);
  endtask

  task automatic compare_mem_a();
    for (int x = 0; x < 256; x++)
      check_output($sformatf("A mem[%0d]", x), 32'(mem_a[x]), gold[x]);
    check_output("A queue drained", qa.size(), 32'd0);
  endtask

  task automatic compare_mem_b();
    for (int x = 0; x < 16; x++)
      check_output($sformatf("B mem[%0d]", x), 32'(mem_b[x]), gold[x]);
    check_output("B queue drained", qb.size(), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    wr_cnt_a  = 0;
    wr_cnt_b  = 0;
    reset     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    sec_key_a = '0;
    key_len_a = '0;
    sec_key_b = '0;
    key_len_b = '0;
    init_a    = 1'b0;
    init_b    = 1'b0;

    // Reset values
    #2;
    check_output("reset address", 32'(addr_a), 32'd0);
    check_output("reset data", 32'(data_a), 32'd0);
    check_output("reset wren", 32'(wren_a), 32'd0);
    check_output("reset busy", 32'(busy_a), 32'd0);
    check_output("reset done", 32'(done_a), 32'd0);
    check_output("reset err", 32'(err_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    init_mems();

    // Illegal key_len=0 on A: straight to DONE with err, no writes
    $display("[TB] key_len=0 on A");
    apply_start_a(24'h123456, 2'd0);
    cyc = 0;
    while (!(done_a && err_a) && cyc < 2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("A klen0 done", 32'(done_a), 32'd1);
    check_output("A klen0 err", 32'(err_a), 32'd1);
    check_output("A klen0 busy", 32'(busy_a), 32'd0);

    // Illegal key_len=5 on B (KEY_BYTES_MAX=4)
    $display("[TB] key_len=5 on B");
    apply_start_b(32'h01020304, 3'd5);
    cyc = 0;
    while (!(done_b && err_b) && cyc < 2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("B klen5 done", 32'(done_b), 32'd1);
    check_output("B klen5 err", 32'(err_b), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_output("illegal runs no writes", wr_cnt_a + wr_cnt_b, 32'd0);

    // key 0x01, len 1: first swap writes mem[0]=1 then mem[1]=0
    $display("[TB] key 0x010000 len 1");
    run_model(256, LAT_A, 32'h00010000, 3, 1, 1'b0, exp_cycles, iter100);
    apply_start_a(24'h010000, 2'd1);
    check_output("A busy after start", 32'(busy_a), 32'd1);
    check_output("A done cleared", 32'(done_a), 32'd0);
    check_output("A err cleared", 32'(err_a), 32'd0);
    cyc = 0;
    while (!wren_a && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("A first write cycle", cyc, 2 * LAT_A + 5);
    check_output("A WR_I address", 32'(addr_a), 32'd0);
    check_output("A WR_I data", 32'(data_a), 32'h01);
    @(posedge clk);
    #1;
    cyc++;
    check_output("A WR_J wren", 32'(wren_a), 32'd1);
    check_output("A WR_J address", 32'(addr_a), 32'd1);
    check_output("A WR_J data", 32'(data_a), 32'h00);
    @(posedge clk);
    #1;
    cyc++;
    check_output("A NEXT wren low", 32'(wren_a), 32'd0);
    wait_done_a(cyc, 5000, cyc);
    check_output("A key01 cycles", cyc, exp_cycles);
    check_output("A key01 err", 32'(err_a), 32'd0);
    compare_mem_a();

    // key byte 0x00, len 1: iteration 0 has i=j=0 and must not write
    $display("[TB] key 0x000000 len 1");
    init_mems();
    run_model(256, LAT_A, 32'h00000000, 3, 1, 1'b0, exp_cycles, iter100);
    base = wr_cnt_a;
    apply_start_a(24'h000000, 2'd1);
    repeat (6 + 2 * LAT_A) @(posedge clk);
    #1;
    check_output("A skip no write", wr_cnt_a - base, 32'd0);
    check_output("A skip next address", 32'(addr_a), 32'd1);
    wait_done_a(6 + 2 * LAT_A, 5000, cyc);
    check_output("A key00 cycles", cyc, exp_cycles);
    compare_mem_a();

    // "Key" full run
    $display("[TB] key 'Key' len 3");
    init_mems();
    run_model(256, LAT_A, 32'h004B6579, 3, 3, 1'b0, exp_cycles, iter100);
    apply_start_a(24'h4B6579, 2'd3);
    wait_done_a(0, 5000, cyc);
    check_output("A Key cycles", cyc, exp_cycles);
    check_output("A Key busy", 32'(busy_a), 32'd0);
    compare_mem_a();

    // DONE ignores key changes without start
    sec_key_a = 24'hFFFFFF;
    key_len_a = 2'd2;
    repeat (5) @(posedge clk);
    #1;
    check_output("A DONE hold done", 32'(done_a), 32'd1);
    check_output("A DONE hold busy", 32'(busy_a), 32'd0);

    // Reset at iteration 100, then re-run to the golden result
    $display("[TB] reset at iteration 100");
    init_mems();
    run_model(256, LAT_A, 32'h004B6579, 3, 3, 1'b0, exp_cycles, iter100);
    apply_start_a(24'h4B6579, 2'd3);
    repeat (iter100 + 3) @(posedge clk);
    #1;
    check_output("A busy before abort", 32'(busy_a), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort address", 32'(addr_a), 32'd0);
    check_output("abort data", 32'(data_a), 32'd0);
    check_output("abort wren", 32'(wren_a), 32'd0);
    check_output("abort busy", 32'(busy_a), 32'd0);
    check_output("abort done", 32'(done_a), 32'd0);
    check_output("abort err", 32'(err_a), 32'd0);
    qa.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    init_mems();
    run_model(256, LAT_A, 32'h004B6579, 3, 3, 1'b0, exp_cycles, iter100);
    apply_start_a(24'h4B6579, 2'd3);
    wait_done_a(0, 5000, cyc);
    check_output("A rerun cycles", cyc, exp_cycles);
    compare_mem_a();

    // B: 16-entry run with MEM_LAT=3, start pulsed mid-run must be ignored
    $display("[TB] B 16-entry run");
    run_model(16, LAT_B, 32'h1A2B3C4D, 4, 4, 1'b1, exp_cycles, iter100);
    apply_start_b(32'h1A2B3C4D, 3'd4);
    repeat (20) @(posedge clk);
    #1;
    apply_start_b(32'hFFFFFFFF, 3'd2);
    check_output("B busy after stray start", 32'(busy_b), 32'd1);
    wait_done_b(21, 1000, cyc);
    check_output("B cycles", cyc, exp_cycles);
    check_output("B err", 32'(err_b), 32'd0);
    compare_mem_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
